serial_strobe_tx: RTL and testbench
===================================

# serial_strobe_tx

Serial strobe transmitter for the sampled-input interface. A sampling register on the receive side captures a data line only while a qualifying strobe is high. This block is the send side of that interface: it accepts a parallel word, then drives a framed bit stream on `OUT` qualified by `STB`. The frame is a marker bit, the data bits MSB first, an optional even-parity bit, and an idle gap.

## Interface
- `WIDTH`, default 8: data word width, ≥ 2.
- `PARITY_EN`, default 1: 1 appends an even-parity bit after the data; 0 omits it.
- `GAP_CYCLES`, default 2: idle cycles after each frame, with `STB`=0. Must be ≥ 1.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `START` in 1: request to send; sampled only in IDLE.
- `DATA` in WIDTH: word to send; captured on the accepting edge.
- `OUT` out 1: serial data line, registered.
- `STB` out 1: high when `OUT` carries a valid frame bit, registered.
- `BUSY` out 1: high from the accepting edge until the frame completes, registered.
- `DONE` out 1: one-cycle pulse marking the end of a frame, registered.

## Operation
- **States:** IDLE, MARK, SHIFT, PAR, GAP.
- **IDLE:** `OUT`=0, `STB`=0, `BUSY`=0.
  - `START`=1 at an edge: capture `DATA` into the shift register, clear the parity accumulator, go to MARK.
- **MARK:** one cycle, `OUT`=1, `STB`=1. Next state is SHIFT with bit counter = WIDTH-1.
- **SHIFT:** `OUT` = shift register MSB, `STB`=1; the shift register shifts left and the parity accumulator XORs in the sent bit.
  - After WIDTH cycles: go to PAR if `PARITY_EN`=1, otherwise go to GAP.
- **PAR:** one cycle, `STB`=1, `OUT` = XOR of all WIDTH data bits (even parity).
- **GAP:** `OUT`=0, `STB`=0, `BUSY`=1 for exactly GAP_CYCLES cycles. Then go to IDLE.
  - `DONE`=1 during the first IDLE cycle after GAP.
- **START handling:**
  - `START` outside IDLE is ignored; no queuing.
  - `START` held high through the `DONE` cycle starts the next frame on that edge. Back-to-back frames are separated by exactly GAP_CYCLES `STB`-low cycles plus the one IDLE cycle.
- **DATA handling:** changes to `DATA` after the accepting edge have no effect on the frame in flight.
- **Counter:** width is clog2(max(WIDTH, GAP_CYCLES)+1). It is reloaded on every state entry, so it never wraps across states.

## Timing
- **Reset values:** all outputs, the shift register, the counter and the parity accumulator are 0. State is IDLE.
- **Reset assertion:** asynchronous. Outputs clear without waiting for a clock edge, including mid-frame, and no `DONE` pulse is generated for an aborted frame.
- **Reset release:** synchronous to `CLK`; the first accept can occur on the first edge after `RST` goes high.
- **Latency:** `START` sampled at edge k → `STB`=1, `OUT`=1 (marker) after edge k. The first data bit appears after edge k+1.
- **Frame length:** `STB` is high for 1 + WIDTH + PARITY_EN cycles, contiguous.
- **BUSY duration:** high for 1 + WIDTH + PARITY_EN + GAP_CYCLES cycles.
- **DONE timing:** `DONE` rises on the edge where `BUSY` falls and lasts one cycle.
- **Receiver contract:** a receiver sampling `OUT` on every edge where `STB`=1 sees, in order: the marker, then the data MSB→LSB, then parity.

## Test plan
- **Reset:** hold `RST`=0 for 3 cycles while `START`=1 → `OUT`/`STB`/`BUSY`/`DONE` stay 0. Release → accept on the next edge.
- **Single frame** (WIDTH=8, PARITY_EN=1, GAP=2): `DATA`=8'hA5, `START` pulsed for one cycle.
  - `STB`-qualified bits: 1,1,0,1,0,0,1,0,1, then parity 0.
  - `BUSY` high for 12 cycles; `DONE` high for 1 cycle after that.
- **Parity odd case:** `DATA`=8'h01 → parity bit 1.
  - Same data with PARITY_EN=0 → 9 `STB` cycles and no parity bit.
- **Back-to-back frames:** `START` held high, `DATA`=8'hFF then 8'h00, with `DATA` changed mid-frame.
  - First frame sends all 1s unaffected by the change.
  - Exactly 3 `STB`-low cycles between frames; second frame data is 8'h00 with parity 0.
- **START while busy:** pulse `START` during SHIFT with `DATA`=8'h3C → ignored. Only one `DONE`, and no extra frame follows.
- **Reset mid-frame:** assert `RST` during the 4th data bit → outputs go 0 asynchronously with no `DONE`. After release, a new frame with 8'h5A transmits correctly.

Source files
------------

// File: rtl/serial_strobe_tx.sv
// serial_strobe_tx
// Send side of a strobe-qualified serial link. A START in IDLE captures
// DATA and emits a frame on OUT: a marker bit, the data MSB first, an
// optional even-parity bit, then GAP_CYCLES idle cycles with STB low.
// A receiver that samples OUT on every edge where STB=1 recovers the frame.
//
// Ports:
//   CLK    in          rising-edge clock
//   RST    in          asynchronous active-low reset
//   START  in          send request, sampled only in IDLE
//   DATA   in  [WIDTH] word to send, captured on the accepting edge
//   OUT    out         serial data line (registered)
//   STB    out         OUT carries a valid frame bit (registered)
//   BUSY   out         accepting edge until frame completes (registered)
//   DONE   out         one-cycle end-of-frame pulse (registered)
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for START; OUT/STB/BUSY low
// S_MARK  | marker bit (OUT=1, STB=1), one cycle
// S_SHIFT | data bits MSB first, WIDTH cycles
// S_PAR   | even-parity bit, one cycle (PARITY_EN only)
// S_GAP   | STB low, BUSY high for GAP_CYCLES cycles

module serial_strobe_tx #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter int GAP_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA,
    output logic             OUT,
    output logic             STB,
    output logic             BUSY,
    output logic             DONE
);

    localparam int MAXC = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_SHIFT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_GAP   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MARK  = 3'd1,
        S_SHIFT = 3'd2,
        S_PAR   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             out_q, out_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            out_q   <= out_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sreg_d  = DATA;
                    par_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_MARK;
                end
            end
            S_MARK: begin
                cnt_d   = CNT_SHIFT;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // The bit on OUT this cycle is the current MSB; fold it into parity.
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                par_d  = par_q ^ sreg_q[WIDTH-1];
                if (cnt_q == '0) begin
                    if (PARITY_EN) begin
                        cnt_d   = '0;
                        state_d = S_PAR;
                    end else begin
                        cnt_d   = CNT_GAP;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PAR: begin
                cnt_d   = CNT_GAP;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they describe (marker visible right after the accepting edge).
    always_comb begin
        out_d  = 1'b0;
        stb_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_GAP) && (state_d == S_IDLE);
        case (state_d)
            S_MARK: begin
                out_d = 1'b1;
                stb_d = 1'b1;
            end
            S_SHIFT: begin
                out_d = sreg_d[WIDTH-1];
                stb_d = 1'b1;
            end
            S_PAR: begin
                out_d = par_d;
                stb_d = 1'b1;
            end
            default: begin
                out_d = 1'b0;
                stb_d = 1'b0;
            end
        endcase
    end

    assign OUT  = out_q;
    assign STB  = stb_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_serial_strobe_tx.sv
module tb_serial_strobe_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic [7:0] data;
    logic       out1, stb1, busy1, done1;
    logic       out2, stb2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_strobe_tx #(.WIDTH(8), .PARITY_EN(1'b1), .GAP_CYCLES(2)) dut (
        .CLK(clk), .RST(rst), .START(start), .DATA(data),
        .OUT(out1), .STB(stb1), .BUSY(busy1), .DONE(done1)
    );

    serial_strobe_tx #(.WIDTH(8), .PARITY_EN(1'b0), .GAP_CYCLES(2)) dut_np (
        .CLK(clk), .RST(rst), .START(start2), .DATA(data),
        .OUT(out2), .STB(stb2), .BUSY(busy2), .DONE(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame request and records what a receiver would see.
    // Called and returns at a negedge; returns at the DONE cycle.
    task automatic frame(input bit np, input logic [7:0] d, input bit hold,
                         input int chg_at, input logic [7:0] d_chg, input int pulse_at,
                         output logic [15:0] bits, output int nb, output int busy_n,
                         output int done_n, output int trail_low, output bit first_stb,
                         output bit busy_at_done, output bit timed_out);
        logic o, s, b, dn;
        bits = '0; nb = 0; busy_n = 0; done_n = 0; trail_low = 0;
        first_stb = 1'b0; busy_at_done = 1'b1; timed_out = 1'b1;
        data = d;
        if (np) start2 = 1'b1; else start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            o  = np ? out2  : out1;
            s  = np ? stb2  : stb1;
            b  = np ? busy2 : busy1;
            dn = np ? done2 : done1;
            if (i == 0) first_stb = s;
            if (s) begin
                bits = {bits[14:0], o};
                nb++;
                trail_low = 0;
            end else begin
                trail_low++;
            end
            if (b) busy_n++;
            if (!hold) begin
                start  = 1'b0;
                start2 = 1'b0;
            end
            if (i == pulse_at) begin
                start = 1'b1;
                data  = 8'h3C;
            end
            if (i == chg_at) data = d_chg;
            if (dn) begin
                done_n++;
                busy_at_done = b;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] bits;
        int nb, busy_n, done_n, trail_low, act;
        bit first_stb, busy_at_done, timed_out;

        // Reset held with START high: nothing may leave the block.
        rst = 1'b0; start = 1'b1; start2 = 1'b0; data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", {out1, stb1, busy1, done1}, 4'b0000);
        end
        rst = 1'b1;

        // Single frame A5: accept on first edge after release.
        frame(1'b0, 8'hA5, 1'b0, -1, 8'h00, -1, bits, nb, busy_n, done_n,
              trail_low, first_stb, busy_at_done, timed_out);
        chk("a5_timeout", timed_out, 0);
        chk("a5_first_accept", first_stb, 1);
        chk("a5_bits", bits, 16'b0000_0011_0100_1010);
        chk("a5_nbits", nb, 10);
        chk("a5_busy_cycles", busy_n, 12);
        chk("a5_done_busy_low", busy_at_done, 0);
        @(negedge clk);
        chk("a5_done_one_cycle", done1, 0);

        // Odd parity word.
        frame(1'b0, 8'h01, 1'b0, -1, 8'h00, -1, bits, nb, busy_n, done_n,
              trail_low, first_stb, busy_at_done, timed_out);
        chk("p01_timeout", timed_out, 0);
        chk("p01_bits", bits, 16'b0000_0010_0000_0011);
        chk("p01_nbits", nb, 10);

        // Same word without parity.
        frame(1'b1, 8'h01, 1'b0, -1, 8'h00, -1, bits, nb, busy_n, done_n,
              trail_low, first_stb, busy_at_done, timed_out);
        chk("np01_timeout", timed_out, 0);
        chk("np01_bits", bits, 16'b0000_0001_0000_0001);
        chk("np01_nbits", nb, 9);
        chk("np01_busy_cycles", busy_n, 11);

        // Back-to-back frames with START held; DATA changes mid-frame.
        @(negedge clk);
        frame(1'b0, 8'hFF, 1'b1, 4, 8'h00, -1, bits, nb, busy_n, done_n,
              trail_low, first_stb, busy_at_done, timed_out);
        chk("ff_timeout", timed_out, 0);
        chk("ff_bits", bits, 16'b0000_0011_1111_1110);
        chk("ff_gap_low", trail_low, 3);
        frame(1'b0, 8'h00, 1'b0, -1, 8'h00, -1, bits, nb, busy_n, done_n,
              trail_low, first_stb, busy_at_done, timed_out);
        chk("b2b_immediate_start", first_stb, 1);
        chk("b00_timeout", timed_out, 0);
        chk("b00_bits", bits, 16'b0000_0010_0000_0000);
        chk("b00_nbits", nb, 10);

        // START pulse during SHIFT is ignored.
        @(negedge clk);
        frame(1'b0, 8'hA5, 1'b0, -1, 8'h00, 3, bits, nb, busy_n, done_n,
              trail_low, first_stb, busy_at_done, timed_out);
        chk("busy_start_timeout", timed_out, 0);
        chk("busy_start_bits", bits, 16'b0000_0011_0100_1010);
        act = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (stb1 || busy1 || done1) act++;
        end
        chk("busy_start_no_extra", act, 0);

        // Reset during the 4th data bit.
        data = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("mid_frame_active", {stb1, busy1}, 2'b11);
        #1 rst = 1'b0;
        #1 chk("async_reset_outputs", {out1, stb1, busy1, done1}, 4'b0000);
        act = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out1 || stb1 || busy1 || done1) act++;
        end
        chk("reset_no_done", act, 0);
        rst = 1'b1;
        frame(1'b0, 8'h5A, 1'b0, -1, 8'h00, -1, bits, nb, busy_n, done_n,
              trail_low, first_stb, busy_at_done, timed_out);
        chk("r5a_timeout", timed_out, 0);
        chk("r5a_bits", bits, 16'b0000_0010_1011_0100);
        chk("r5a_busy_cycles", busy_n, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
